// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// The control-vector presets below are what each FSM situation drives onto the stage enables.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    typedef struct packed {
        logic dmem_req;
        logic pc_write_en;
        logic if_id_write_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic id_ex_hold;
        logic ex_mem_bubble;
        logic ex_mem_hold;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_INIT = '{
        dmem_req: 1'b0, pc_write_en: 1'b0, if_id_write_en: 1'b0, if_id_flush: 1'b1,
        id_ex_bubble: 1'b1, id_ex_hold: 1'b0, ex_mem_bubble: 1'b1, ex_mem_hold: 1'b0,
        mem_wb_bubble: 1'b1};

    localparam ctrl_t CTRL_RUN = '{
        dmem_req: 1'b0, pc_write_en: 1'b1, if_id_write_en: 1'b1, if_id_flush: 1'b0,
        id_ex_bubble: 1'b0, id_ex_hold: 1'b0, ex_mem_bubble: 1'b0, ex_mem_hold: 1'b0,
        mem_wb_bubble: 1'b0};

    // Front of the pipe holds while MEM waits; WB receives bubbles until the access resolves.
    localparam ctrl_t CTRL_FREEZE = '{
        dmem_req: 1'b1, pc_write_en: 1'b0, if_id_write_en: 1'b0, if_id_flush: 1'b0,
        id_ex_bubble: 1'b0, id_ex_hold: 1'b1, ex_mem_bubble: 1'b0, ex_mem_hold: 1'b1,
        mem_wb_bubble: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a load in EX whose destination is read by the ID instruction.
// Writes to x0 never create a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    output logic       o_hazard
);
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_hazard  = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: reset bubbling, data-memory freeze/timeout, MEM redirect flush, load-use stall.
// Define PIPE_HAZARD_PERF_EN to add the stall_cycles / flush_count performance counters.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_INIT     | post-reset: whole pipe bubbled for INIT_CYCLES cycles
//   ST_RUN      | normal flow; memory > redirect > load-use priority
//   ST_MEM_WAIT | data access outstanding: pipe frozen until ack or timeout
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_use_rs1,
    input  logic        i_id_use_rs2,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_mem_read,
    input  logic        i_mem_redirect,
    input  logic        i_mem_access,
    input  logic        i_dmem_ack,
    output logic        o_dmem_req,
    output logic        o_pc_write_en,
    output logic        o_if_id_write_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_bubble,
    output logic        o_id_ex_hold,
    output logic        o_ex_mem_bubble,
    output logic        o_ex_mem_hold,
    output logic        o_mem_wb_bubble,
    output logic        o_timeout_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
`endif
);
    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [3:0] r_init_cnt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    logic       r_timeout_err;
    logic       w_timeout;
    logic       w_load_use;
    ctrl_t      w_ctrl;

    load_use_detect u_load_use_detect (
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_use_rs1  (i_id_use_rs1),
        .i_id_use_rs2  (i_id_use_rs2),
        .o_hazard      (w_load_use)
    );

    always_comb begin
        w_ctrl         = CTRL_INIT;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout      = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == INIT_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_ctrl = CTRL_RUN;
                if (i_mem_access && !i_dmem_ack) begin
                    // Hazards seen this cycle are dropped; they re-present after the freeze.
                    w_ctrl         = CTRL_FREEZE;
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end else begin
                    w_ctrl.dmem_req = i_mem_access;
                    if (i_mem_redirect) begin
                        w_ctrl.if_id_flush   = 1'b1;
                        w_ctrl.id_ex_bubble  = 1'b1;
                        w_ctrl.ex_mem_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_ctrl.pc_write_en    = 1'b0;
                        w_ctrl.if_id_write_en = 1'b0;
                        w_ctrl.id_ex_bubble   = 1'b1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (i_dmem_ack) begin
                    w_ctrl          = CTRL_RUN;
                    w_ctrl.dmem_req = 1'b1;
                    w_state_nxt     = ST_RUN;
                    w_wait_cnt_nxt  = 8'd0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    // Abandon the access: the pipe moves on and the load result never reaches WB.
                    w_ctrl               = CTRL_RUN;
                    w_ctrl.mem_wb_bubble = 1'b1;
                    w_timeout            = 1'b1;
                    w_state_nxt          = ST_RUN;
                    w_wait_cnt_nxt       = 8'd0;
                end else begin
                    w_ctrl         = CTRL_FREEZE;
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
        if (i_rst) w_ctrl = CTRL_INIT;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_INIT;
            r_init_cnt    <= 4'd0;
            r_wait_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 4'd1;
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if ((r_state != ST_INIT) && !w_ctrl.pc_write_en)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if ((r_state == ST_RUN) && w_ctrl.if_id_flush)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`endif

    assign o_dmem_req       = w_ctrl.dmem_req;
    assign o_pc_write_en    = w_ctrl.pc_write_en;
    assign o_if_id_write_en = w_ctrl.if_id_write_en;
    assign o_if_id_flush    = w_ctrl.if_id_flush;
    assign o_id_ex_bubble   = w_ctrl.id_ex_bubble;
    assign o_id_ex_hold     = w_ctrl.id_ex_hold;
    assign o_ex_mem_bubble  = w_ctrl.ex_mem_bubble;
    assign o_ex_mem_hold    = w_ctrl.ex_mem_hold;
    assign o_mem_wb_bubble  = w_ctrl.mem_wb_bubble;
    assign o_timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change on the falling edge, outputs checked 1ns later.
module tb_pipe_hazard_ctrl;

    // {dmem_req, pc_we, if_id_we, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, ex_mem_hold, mem_wb_bubble}
    localparam logic [8:0] C_INIT   = 9'b0_0_0_1_1_0_1_0_1;
    localparam logic [8:0] C_RUN    = 9'b0_1_1_0_0_0_0_0_0;
    localparam logic [8:0] C_FREEZE = 9'b1_0_0_0_0_1_0_1_1;
    localparam logic [8:0] C_REDIR  = 9'b0_1_1_1_1_0_1_0_0;
    localparam logic [8:0] C_LU     = 9'b0_0_0_0_1_0_0_0_0;
    localparam logic [8:0] C_RUNREQ = 9'b1_1_1_0_0_0_0_0_0;
    localparam logic [8:0] C_REDREQ = 9'b1_1_1_1_1_0_1_0_0;
    localparam logic [8:0] C_TMO    = 9'b0_1_1_0_0_0_0_0_1;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [4:0] i_id_rs1 = 5'd0, i_id_rs2 = 5'd0, i_ex_rd = 5'd0;
    logic       i_id_use_rs1 = 1'b0, i_id_use_rs2 = 1'b0, i_ex_mem_read = 1'b0;
    logic       i_mem_redirect = 1'b0, i_mem_access = 1'b0, i_dmem_ack = 1'b0;
    logic       o_dmem_req, o_pc_write_en, o_if_id_write_en, o_if_id_flush, o_id_ex_bubble;
    logic       o_id_ex_hold, o_ex_mem_bubble, o_ex_mem_hold, o_mem_wb_bubble, o_timeout_err;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] o_stall_cycles, o_flush_count;
`endif
    logic [8:0] ctl;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    pipe_hazard_ctrl #(.INIT_CYCLES(4), .MEM_TIMEOUT(16)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_id_rs1         (i_id_rs1),
        .i_id_rs2         (i_id_rs2),
        .i_id_use_rs1     (i_id_use_rs1),
        .i_id_use_rs2     (i_id_use_rs2),
        .i_ex_rd          (i_ex_rd),
        .i_ex_mem_read    (i_ex_mem_read),
        .i_mem_redirect   (i_mem_redirect),
        .i_mem_access     (i_mem_access),
        .i_dmem_ack       (i_dmem_ack),
        .o_dmem_req       (o_dmem_req),
        .o_pc_write_en    (o_pc_write_en),
        .o_if_id_write_en (o_if_id_write_en),
        .o_if_id_flush    (o_if_id_flush),
        .o_id_ex_bubble   (o_id_ex_bubble),
        .o_id_ex_hold     (o_id_ex_hold),
        .o_ex_mem_bubble  (o_ex_mem_bubble),
        .o_ex_mem_hold    (o_ex_mem_hold),
        .o_mem_wb_bubble  (o_mem_wb_bubble),
        .o_timeout_err    (o_timeout_err)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .o_stall_cycles   (o_stall_cycles),
        .o_flush_count    (o_flush_count)
`endif
    );

    assign ctl = {o_dmem_req, o_pc_write_en, o_if_id_write_en, o_if_id_flush, o_id_ex_bubble,
                  o_id_ex_hold, o_ex_mem_bubble, o_ex_mem_hold, o_mem_wb_bubble};

    // Two reset cycles, then exactly four bubbled INIT cycles before RUN.
    task automatic test_reset();
        @(negedge i_clk); #1;
        n_checks++; if (ctl !== C_INIT) begin n_fail++; $display("FAIL rst_cyc0: ctl=%b expected %b", ctl, C_INIT); end
        n_checks++; if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_terr: got %b expected 0", o_timeout_err); end
        @(negedge i_clk); i_rst = 1'b0; #1;
        n_checks++; if (ctl !== C_INIT) begin n_fail++; $display("FAIL init_cyc0: ctl=%b expected %b", ctl, C_INIT); end
        for (int i = 1; i < 4; i++) begin
            @(negedge i_clk); #1;
            n_checks++; if (ctl !== C_INIT) begin n_fail++; $display("FAIL init_cyc%0d: ctl=%b expected %b", i, ctl, C_INIT); end
        end
        @(negedge i_clk); #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL init_to_run: ctl=%b expected %b", ctl, C_RUN); end
    endtask

    task automatic test_load_use();
        @(negedge i_clk); i_ex_mem_read = 1'b1; i_ex_rd = 5'd5; i_id_rs1 = 5'd5; i_id_use_rs1 = 1'b1; #1;
        n_checks++; if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs1: ctl=%b expected %b", ctl, C_LU); end
        @(negedge i_clk); i_ex_mem_read = 1'b0; #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_release: ctl=%b expected %b", ctl, C_RUN); end
        @(negedge i_clk); i_ex_mem_read = 1'b1; i_ex_rd = 5'd0; i_id_rs1 = 5'd0; #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_x0: ctl=%b expected %b", ctl, C_RUN); end
        @(negedge i_clk); i_ex_rd = 5'd7; i_id_rs1 = 5'd3; i_id_rs2 = 5'd7; i_id_use_rs2 = 1'b1; #1;
        n_checks++; if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs2: ctl=%b expected %b", ctl, C_LU); end
        @(negedge i_clk); i_id_use_rs2 = 1'b0; i_id_rs1 = 5'd7; i_id_use_rs1 = 1'b0; #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_unused_src: ctl=%b expected %b", ctl, C_RUN); end
        @(negedge i_clk); i_ex_mem_read = 1'b0; i_id_use_rs1 = 1'b1; #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_not_load: ctl=%b expected %b", ctl, C_RUN); end
        i_id_use_rs1 = 1'b0; i_ex_rd = 5'd0; i_id_rs1 = 5'd0; i_id_rs2 = 5'd0;
    endtask

    task automatic test_redirect();
        @(negedge i_clk); i_mem_redirect = 1'b1; #1;
        n_checks++; if (ctl !== C_REDIR) begin n_fail++; $display("FAIL redir: ctl=%b expected %b", ctl, C_REDIR); end
        @(negedge i_clk); i_mem_redirect = 1'b0; #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL redir_after: ctl=%b expected %b", ctl, C_RUN); end
        @(negedge i_clk); i_mem_redirect = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd9;
        i_id_rs1 = 5'd9; i_id_use_rs1 = 1'b1; #1;
        n_checks++; if (ctl !== C_REDIR) begin n_fail++; $display("FAIL redir_over_lu: ctl=%b expected %b", ctl, C_REDIR); end
        @(negedge i_clk); i_mem_redirect = 1'b0; i_ex_mem_read = 1'b0; i_id_use_rs1 = 1'b0; #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL redir_idle: ctl=%b expected %b", ctl, C_RUN); end
    endtask

    task automatic test_mem_wait();
        @(negedge i_clk); i_mem_access = 1'b1; i_dmem_ack = 1'b1; #1;
        n_checks++; if (ctl !== C_RUNREQ) begin n_fail++; $display("FAIL mem_zero_wait: ctl=%b expected %b", ctl, C_RUNREQ); end
        @(negedge i_clk); i_mem_redirect = 1'b1; #1;
        n_checks++; if (ctl !== C_REDREQ) begin n_fail++; $display("FAIL mem_zero_wait_redir: ctl=%b expected %b", ctl, C_REDREQ); end
        @(negedge i_clk); i_mem_redirect = 1'b0; i_dmem_ack = 1'b0; #1;
        n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL mem_freeze0: ctl=%b expected %b", ctl, C_FREEZE); end
        for (int i = 1; i < 3; i++) begin
            @(negedge i_clk); #1;
            n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL mem_freeze%0d: ctl=%b expected %b", i, ctl, C_FREEZE); end
        end
        @(negedge i_clk); i_dmem_ack = 1'b1; #1;
        n_checks++; if (ctl !== C_RUNREQ) begin n_fail++; $display("FAIL mem_ack_release: ctl=%b expected %b", ctl, C_RUNREQ); end
        @(negedge i_clk); i_dmem_ack = 1'b0; i_mem_access = 1'b0; #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL mem_back_to_run: ctl=%b expected %b", ctl, C_RUN); end
    endtask

    // ack_at_last=0: access dropped at the 16th wait cycle; ack_at_last=1: ack on that cycle wins.
    task automatic test_timeout(input bit ack_at_last, input logic exp_err);
        @(negedge i_clk); i_mem_access = 1'b1; i_dmem_ack = 1'b0; #1;
        n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL tmo_start: ctl=%b expected %b", ctl, C_FREEZE); end
        for (int i = 1; i < 16; i++) begin
            @(negedge i_clk); #1;
            n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL tmo_wait%0d: ctl=%b expected %b", i, ctl, C_FREEZE); end
        end
        @(negedge i_clk); i_mem_access = 1'b0; i_dmem_ack = ack_at_last; #1;
        if (ack_at_last) begin
            n_checks++; if (ctl !== C_RUNREQ) begin n_fail++; $display("FAIL tmo_ack_wins: ctl=%b expected %b", ctl, C_RUNREQ); end
        end else begin
            n_checks++; if (ctl !== C_TMO) begin n_fail++; $display("FAIL tmo_abort: ctl=%b expected %b", ctl, C_TMO); end
        end
        n_checks++; if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_early: got %b expected 0", o_timeout_err); end
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk); i_dmem_ack = 1'b0; #1;
            n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL tmo_run%0d: ctl=%b expected %b", i, ctl, C_RUN); end
            n_checks++; if (o_timeout_err !== exp_err) begin n_fail++; $display("FAIL tmo_err%0d: got %b expected %b", i, o_timeout_err, exp_err); end
        end
    endtask

    task automatic test_rst_mid_wait();
        @(negedge i_clk); i_mem_access = 1'b1; #1;
        n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL rstw_freeze: ctl=%b expected %b", ctl, C_FREEZE); end
        @(negedge i_clk); i_rst = 1'b1; #1;
        n_checks++; if (ctl !== C_INIT) begin n_fail++; $display("FAIL rstw_during: ctl=%b expected %b", ctl, C_INIT); end
        @(negedge i_clk); i_rst = 1'b0; i_mem_access = 1'b0; #1;
        n_checks++; if (ctl !== C_INIT) begin n_fail++; $display("FAIL rstw_init: ctl=%b expected %b", ctl, C_INIT); end
        n_checks++; if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstw_terr_clr: got %b expected 0", o_timeout_err); end
        for (int i = 1; i < 4; i++) @(negedge i_clk);
        @(negedge i_clk); #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL rstw_run: ctl=%b expected %b", ctl, C_RUN); end
    endtask

    // Memory stall hides a simultaneous redirect and load-use; the redirect is honoured afterwards.
    task automatic test_priority();
        @(negedge i_clk); i_mem_access = 1'b1; i_mem_redirect = 1'b1; i_ex_mem_read = 1'b1;
        i_ex_rd = 5'd4; i_id_rs2 = 5'd4; i_id_use_rs2 = 1'b1; #1;
        n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL prio_freeze0: ctl=%b expected %b", ctl, C_FREEZE); end
        for (int i = 1; i < 3; i++) begin
            @(negedge i_clk); #1;
            n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL prio_freeze%0d: ctl=%b expected %b", i, ctl, C_FREEZE); end
        end
        @(negedge i_clk); i_dmem_ack = 1'b1; #1;
        n_checks++; if ({o_dmem_req, o_id_ex_hold, o_ex_mem_hold} !== 3'b100) begin
            n_fail++; $display("FAIL prio_ack: req/holds=%b expected 100", {o_dmem_req, o_id_ex_hold, o_ex_mem_hold}); end
        @(negedge i_clk); i_dmem_ack = 1'b0; i_mem_access = 1'b0; #1;
        n_checks++; if (ctl !== C_REDIR) begin n_fail++; $display("FAIL prio_redir_after: ctl=%b expected %b", ctl, C_REDIR); end
        @(negedge i_clk); i_mem_redirect = 1'b0; i_ex_mem_read = 1'b0; i_id_use_rs2 = 1'b0; #1;
        n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL prio_idle: ctl=%b expected %b", ctl, C_RUN); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout(1'b0, 1'b1);
        test_rst_mid_wait();
        test_timeout(1'b1, 1'b0);
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
